// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Frame layout: SYNC, CMD, ARG_HI, ARG_LO, CHK.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    AHI,
    ALO,
    CHK
  } state_e;

  localparam int unsigned FRAME_LEN       = 5;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'h55;
  localparam int unsigned TIMEOUT_CYC_DEF = 312500;

  // 8-bit modular sum of CMD, ARG_HI and ARG_LO.
  function automatic logic [7:0] frame_sum(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the parser and the
// I2C sensor sequencer.
interface uart_cmd_parser_if;

  logic [7:0]  rx_data;
  logic        rx_done_sig;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic        chk_err;
  logic        to_err;
  logic        ovr_err;

  // Parser side.
  modport slave (
    input  rx_data, rx_done_sig, cmd_ready,
    output cmd_valid, cmd_code, cmd_arg, chk_err, to_err, ovr_err
  );

  // Environment side: byte source plus command consumer.
  modport master (
    output rx_data, rx_done_sig, cmd_ready,
    input  cmd_valid, cmd_code, cmd_arg, chk_err, to_err, ovr_err
  );

endinterface

// File: rtl/uart_cmd_parser_byte_timeout_timer.sv
// Inter-byte timer: counts idle cycles while enabled and strobes expire_o in
// the cycle the count sits at TIMEOUT_CYC-1 without a clear.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 312500,
  parameter int unsigned TO_W        = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    expire_o = enable_i && !clear_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));
    if (clear_i || expire_o || !enable_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from the UART byte stream, validates the
// checksum and holds the decoded command on a valid/ready port.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TO_W        = 19
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_parser_if.slave bus
);

  state_e      state_q;
  logic [7:0]  cmd_sh_q;
  logic [7:0]  ahi_sh_q;
  logic [7:0]  alo_sh_q;
  logic        valid_q;
  logic [7:0]  code_q;
  logic [15:0] arg_q;
  logic        chk_err_q;
  logic        to_err_q;
  logic        ovr_err_q;

  logic        tmr_en_d;
  logic        tmr_clear_d;
  logic        expire;
  logic        accept_d;
  logic        out_free_d;
  logic        sum_ok_d;

  always_comb begin
    tmr_en_d    = (state_q != HUNT);
    tmr_clear_d = bus.rx_done_sig;
    accept_d    = valid_q & bus.cmd_ready;
    // Output can take a new frame if empty or being drained this very cycle.
    out_free_d  = ~valid_q | bus.cmd_ready;
    sum_ok_d    = (frame_sum(cmd_sh_q, ahi_sh_q, alo_sh_q) == bus.rx_data);
  end

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear_d),
    .enable_i (tmr_en_d),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      cmd_sh_q  <= '0;
      ahi_sh_q  <= '0;
      alo_sh_q  <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      arg_q     <= '0;
      chk_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      chk_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ovr_err_q <= 1'b0;

      if (accept_d) begin
        valid_q <= 1'b0;
      end

      // A byte strobe takes priority over a coincident timer expiry.
      if (bus.rx_done_sig) begin
        unique case (state_q)
          HUNT: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state_q <= CMD;
            end
          end
          CMD: begin
            cmd_sh_q <= bus.rx_data;
            state_q  <= AHI;
          end
          AHI: begin
            ahi_sh_q <= bus.rx_data;
            state_q  <= ALO;
          end
          ALO: begin
            alo_sh_q <= bus.rx_data;
            state_q  <= CHK;
          end
          CHK: begin
            state_q <= HUNT;
            if (!sum_ok_d) begin
              chk_err_q <= 1'b1;
            end else if (out_free_d) begin
              valid_q <= 1'b1;
              code_q  <= cmd_sh_q;
              arg_q   <= {ahi_sh_q, alo_sh_q};
            end else begin
              ovr_err_q <= 1'b1;
            end
          end
        endcase
      end else if (expire) begin
        state_q  <= HUNT;
        to_err_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_code  = code_q;
  assign bus.cmd_arg   = arg_q;
  assign bus.chk_err   = chk_err_q;
  assign bus.to_err    = to_err_q;
  assign bus.ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames from the test plan, then random
// byte streams, all compared against a queue-based frame model every cycle.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .SYNC_BYTE   (8'h55),
    .TIMEOUT_CYC (TO),
    .TO_W        (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the partial frame kept in a queue.
  logic [7:0]  fq[$];
  int unsigned idle    = 0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_code  = '0;
  logic [15:0] m_arg   = '0;
  logic        m_chk   = 1'b0;
  logic        m_to    = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_acc;
  logic        m_load;
  int unsigned m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      idle = 0;
      m_valid = 1'b0; m_code = '0; m_arg = '0;
      m_chk = 1'b0; m_to = 1'b0; m_ovr = 1'b0;
    end else begin
      m_acc  = m_valid && bus.cmd_ready;
      m_load = 1'b0;
      m_chk = 1'b0; m_to = 1'b0; m_ovr = 1'b0;
      if (bus.rx_done_sig) begin
        idle = 0;
        if (fq.size() != 0 || bus.rx_data == 8'h55) fq.push_back(bus.rx_data);
        if (fq.size() == 5) begin
          m_sum = (int'(fq[1]) + int'(fq[2]) + int'(fq[3])) % 256;
          if (m_sum == 32'(fq[4])) begin
            if (!m_valid || m_acc) begin
              m_code = fq[1];
              m_arg  = {fq[2], fq[3]};
              m_load = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end else begin
            m_chk = 1'b1;
          end
          fq.delete();
        end
      end else if (fq.size() != 0) begin
        idle++;
        if (idle == TO) begin
          fq.delete();
          idle = 0;
          m_to = 1'b1;
        end
      end
      if (m_load) m_valid = 1'b1;
      else if (m_acc) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check_eq("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
    check_eq("cmd_code",  32'(bus.cmd_code),  32'(m_code));
    check_eq("cmd_arg",   32'(bus.cmd_arg),   32'(m_arg));
    check_eq("chk_err",   32'(bus.chk_err),   32'(m_chk));
    check_eq("to_err",    32'(bus.to_err),    32'(m_to));
    check_eq("ovr_err",   32'(bus.ovr_err),   32'(m_ovr));
  end

  // Observed event counters for the directed checks.
  int unsigned n_acc = 0, n_chk = 0, n_to = 0, n_ovr = 0;
  logic [7:0]  last_code = '0;
  logic [15:0] last_arg  = '0;

  always @(posedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      n_acc++;
      last_code = bus.cmd_code;
      last_arg  = bus.cmd_arg;
    end
  end

  always @(negedge clk) begin
    if (bus.chk_err) n_chk++;
    if (bus.to_err)  n_to++;
    if (bus.ovr_err) n_ovr++;
  end

  bit rdy_rand = 1'b0;

  // gap = clock edges from this strobe to the next one (>= 2).
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    @(negedge clk); #1;
    bus.rx_data = b;
    bus.rx_done_sig = 1'b1;
    if (rdy_rand) bus.cmd_ready = ($urandom_range(0, 2) != 0);
    @(negedge clk); #1;
    bus.rx_done_sig = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] a,
                            input logic [7:0] k, input int unsigned gap);
    send_byte(8'h55, gap);
    send_byte(c, gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
    send_byte(k, gap);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.cmd_valid), 0);
    check_eq({tag, "_code"},  32'(bus.cmd_code),  0);
    check_eq({tag, "_arg"},   32'(bus.cmd_arg),   0);
    check_eq({tag, "_errs"},  32'({bus.chk_err, bus.to_err, bus.ovr_err}), 0);
  endtask

  function automatic int unsigned pick_gap();
    int unsigned r;
    r = $urandom_range(0, 39);
    if (r == 0) return TO;
    if (r == 1) return TO + 1 + $urandom_range(0, 3);
    return $urandom_range(2, 8);
  endfunction

  int unsigned a0, c0, t0, o0, k;
  logic [7:0]  rc, rk;
  logic [15:0] ra;

  initial begin
    bus.rx_data = '0;
    bus.rx_done_sig = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (3) @(negedge clk); #1;
    check_outputs_zero("in_reset");
    rst = 1'b0;
    settle();
    check_outputs_zero("post_reset");

    // Good frame, accepted immediately.
    bus.cmd_ready = 1'b1;
    a0 = n_acc; c0 = n_chk; t0 = n_to; o0 = n_ovr;
    send_frame(8'h12, 16'h3456, 8'h9C, 5);
    settle();
    check_eq("good_acc", n_acc - a0, 1);
    check_eq("good_code", 32'(last_code), 32'h12);
    check_eq("good_arg", 32'(last_arg), 32'h3456);
    check_eq("good_errs", (n_chk - c0) + (n_to - t0) + (n_ovr - o0), 0);

    // Bad checksum, then a frame whose sum wraps to zero.
    send_frame(8'h12, 16'h3456, 8'h9D, 3);
    settle();
    check_eq("bad_chk_pulses", n_chk - c0, 1);
    check_eq("bad_no_acc", n_acc - a0, 1);
    send_frame(8'h01, 16'h00FF, 8'h00, 3);
    settle();
    check_eq("wrap_code", 32'(last_code), 32'h01);
    check_eq("wrap_arg", 32'(last_arg), 32'h00FF);

    // Junk before a frame is ignored silently.
    c0 = n_chk;
    send_byte(8'h00, 3); send_byte(8'hAA, 3); send_byte(8'h7F, 3);
    send_frame(8'h20, 16'h0010, 8'h30, 3);
    settle();
    check_eq("junk_code", 32'(last_code), 32'h20);
    check_eq("junk_arg", 32'(last_arg), 32'h0010);
    check_eq("junk_no_chk", n_chk - c0, 0);

    // Timeout latency measured from the CMD strobe edge.
    t0 = n_to;
    send_byte(8'h55, 3);
    @(negedge clk); #1;
    bus.rx_data = 8'h12;
    bus.rx_done_sig = 1'b1;
    @(posedge clk); #1;
    bus.rx_done_sig = 1'b0;
    k = 0;
    while (k < TO + 10 && !bus.to_err) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("to_latency", k, TO);
    @(posedge clk); #1;
    check_eq("to_width", 32'(bus.to_err), 0);
    a0 = n_acc;
    send_frame(8'h12, 16'h3456, 8'h9C, 4);
    settle();
    check_eq("after_to_acc", n_acc - a0, 1);
    check_eq("after_to_code", 32'(last_code), 32'h12);

    // Strobes exactly at the terminal count: byte wins.
    t0 = n_to;
    send_frame(8'hAB, 16'hCDEF, 8'h67, TO);
    settle();
    check_eq("tc_no_to", n_to - t0, 1 - 1);
    check_eq("tc_code", 32'(last_code), 32'hAB);
    check_eq("tc_arg", 32'(last_arg), 32'hCDEF);

    // Overrun: A held, B dropped.
    bus.cmd_ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    send_frame(8'h01, 16'h0002, 8'h03, 4);
    send_frame(8'h04, 16'h0005, 8'h09, 4);
    settle();
    check_eq("ovr_valid", 32'(bus.cmd_valid), 1);
    check_eq("ovr_hold_code", 32'(bus.cmd_code), 32'h01);
    check_eq("ovr_hold_arg", 32'(bus.cmd_arg), 32'h0002);
    check_eq("ovr_pulses", n_ovr - o0, 1);
    bus.cmd_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("ovr_drain_valid", 32'(bus.cmd_valid), 0);
    check_eq("ovr_drain_acc", n_acc - a0, 1);
    check_eq("ovr_drain_code", 32'(last_code), 32'h01);

    // Back-to-back: ready rises in B's CHK cycle.
    bus.cmd_ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    send_frame(8'h01, 16'h0002, 8'h03, 4);
    send_byte(8'h55, 4); send_byte(8'h04, 4); send_byte(8'h00, 4); send_byte(8'h05, 4);
    @(negedge clk); #1;
    bus.rx_data = 8'h09;
    bus.rx_done_sig = 1'b1;
    bus.cmd_ready = 1'b1;
    @(negedge clk); #1;
    bus.rx_done_sig = 1'b0;
    bus.cmd_ready = 1'b0;
    check_eq("b2b_valid", 32'(bus.cmd_valid), 1);
    check_eq("b2b_code", 32'(bus.cmd_code), 32'h04);
    check_eq("b2b_arg", 32'(bus.cmd_arg), 32'h0005);
    check_eq("b2b_acc_a", n_acc - a0, 1);
    check_eq("b2b_no_ovr", n_ovr - o0, 0);
    bus.cmd_ready = 1'b1;
    settle();

    // Reset mid-frame (output still holds B's code).
    send_byte(8'h55, 3); send_byte(8'h12, 3); send_byte(8'h34, 3);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_midframe");
    @(negedge clk); #1;
    rst = 1'b0;
    a0 = n_acc;
    send_frame(8'h12, 16'h3456, 8'h9C, 3);
    settle();
    check_eq("rst_mf_acc", n_acc - a0, 1);
    check_eq("rst_mf_code", 32'(last_code), 32'h12);
    check_eq("rst_mf_arg", 32'(last_arg), 32'h3456);

    // Reset while a command is held.
    bus.cmd_ready = 1'b0;
    send_frame(8'h12, 16'h3456, 8'h9C, 3);
    settle();
    check_eq("held_valid", 32'(bus.cmd_valid), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_held");
    @(negedge clk); #1;
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    settle();

    // Random streams: junk, corrupted checksums, random gaps and backpressure.
    rdy_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), pick_gap());
      rc = 8'($urandom);
      ra = 16'($urandom);
      rk = rc + ra[15:8] + ra[7:0];
      if ($urandom_range(0, 4) == 0) rk = rk ^ 8'(1 << $urandom_range(0, 7));
      send_byte(8'h55, pick_gap());
      send_byte(rc, pick_gap());
      send_byte(ra[15:8], pick_gap());
      send_byte(ra[7:0], pick_gap());
      send_byte(rk, pick_gap());
    end
    rdy_rand = 1'b0;
    bus.cmd_ready = 1'b1;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Consumes the byte stream from the UART receiver (8-bit data plus one-cycle done strobe) and assembles fixed 5-byte command frames: SYNC, CMD, ARG_HI, ARG_LO, CHK.
Validated frames are presented on a valid/ready command port to the I2C sensor sequencer.
Checksum errors, inter-byte timeouts and output overruns are reported as one-cycle error pulses.

Parameters:
SYNC_BYTE, 8'h55, frame start marker.
TIMEOUT_CYC, 312500, max clk cycles between bytes inside a frame (about 3 byte times at 9600 bps, 100 MHz).
TO_W, 19, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset; asynchronous, active-high
rx_data  in  8  received byte; stable in the cycle rx_done_sig is high
rx_done_sig  in  1  one-cycle strobe, one received byte
cmd_valid  out  1  command frame available
cmd_ready  in  1  downstream accepts the frame when high together with cmd_valid
cmd_code  out  8  CMD byte of the held frame
cmd_arg  out  16  {ARG_HI, ARG_LO} of the held frame
chk_err  out  1  one-cycle pulse: checksum mismatch, frame dropped
to_err  out  1  one-cycle pulse: inter-byte timeout, partial frame dropped
ovr_err  out  1  one-cycle pulse: valid frame dropped because the output was still occupied

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. During and after reset, all outputs are 0, the FSM is in HUNT, and the timer is 0.
- FSM states: HUNT, CMD, AHI, ALO, CHK. Transitions happen only in cycles where rx_done_sig=1, except for timeout.
  - HUNT: a byte equal to SYNC_BYTE moves to CMD. Any other byte is discarded silently, with no error.
  - CMD: latch the byte into the shadow cmd register, go to AHI. A SYNC_BYTE value here is treated as data; there is no resync.
  - AHI: latch the shadow arg[15:8], go to ALO.
  - ALO: latch the shadow arg[7:0], go to CHK.
  - CHK: compute sum = (cmd + arg_hi + arg_lo) mod 256, 8-bit wrap, then go to HUNT.
    - If sum == byte, the frame is good.
    - Otherwise chk_err=1 in the next cycle.
- Good frame:
  - If the output is free (cmd_valid=0), or it is being accepted this cycle (cmd_valid & cmd_ready), load cmd_code/cmd_arg from the shadow.
  - cmd_valid=1 in the next cycle, so latency is 1 clk from the CHK strobe.
  - Otherwise keep the old output unchanged and pulse ovr_err in the next cycle.
- Output hold:
  - cmd_valid, cmd_code and cmd_arg stay stable until the cycle with cmd_valid & cmd_ready.
  - After that cycle, cmd_valid=0 unless a new good frame loaded in that same cycle.
  - cmd_ready while cmd_valid=0 is ignored.
- Timeout:
  - The timer clears on every rx_done_sig and counts only while the state is not HUNT.
  - When the timer reaches TIMEOUT_CYC-1 with no strobe, the FSM goes to HUNT, the timer clears, and to_err pulses in the next cycle.
  - If the strobe and the terminal count coincide, the byte wins: it is processed and no to_err is raised.
  - In HUNT the timer is held at 0.
- Error pulses are mutually exclusive per frame and are exactly 1 cycle wide.
- Reset asserted mid-frame or while cmd_valid=1 drops the frame and output immediately, with no error pulse.

Decomposition:
- Package uart_cmd_pkg:
  - FSM state enum (HUNT, CMD, AHI, ALO, CHK).
  - FRAME_LEN=5.
  - Default SYNC_BYTE and TIMEOUT_CYC constants.
  - A checksum function (8-bit modular sum of 3 bytes).
- One sub-module, byte_timeout_timer (TIMEOUT_CYC, TO_W):
  - Inputs: clear, enable.
  - Output: a one-cycle expire strobe.
- The FSM, shadow registers, output register and handshake logic stay in uart_cmd_parser.

Test Plan:
- Good frame: bytes 55 12 34 56 9C, each about 104167 clk apart, cmd_ready=1 → one cycle after the CHK strobe, cmd_valid=1 with cmd_code=12, cmd_arg=3456; accepted in the same cycle; no error pulses.
- Bad checksum: 55 12 34 56 9D → chk_err 1-cycle pulse, cmd_valid stays 0. A following good frame 55 01 00 FF 00 yields cmd_code=01, cmd_arg=00FF (sum wraps to 00).
- Junk then frame: 00 AA 7F 55 20 00 10 30 → junk ignored silently; cmd_code=20, cmd_arg=0010.
- Timeout:
  - 55 12, then silence → to_err exactly TIMEOUT_CYC cycles after the 12 strobe, FSM back in HUNT.
  - Resend full frame 55 12 34 56 9C → accepted normally.
  - Corner: a byte strobe exactly at the terminal count → no to_err.
- Overrun/backpressure:
  - cmd_ready=0, frames A (55 01 00 02 03) then B (55 04 00 05 09) → A held stable, ovr_err after B's CHK strobe.
  - Raise cmd_ready → A accepted, cmd_valid=0.
  - Repeat with cmd_ready raised exactly in the cycle B completes → B loaded back-to-back, cmd_valid stays 1, no ovr_err.
- Reset: assert rst after 55 12 34 (and separately while cmd_valid=1) → all outputs 0 immediately. After release, frame 55 12 34 56 9C decodes correctly.
